mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port unified instruction/data memory between the multicycle core and the program-loader/debug port. It accepts one transaction at a time from either requester and arbitrates round-robin, with a loader lock that excludes the core. It sequences the memory's fixed read latency and returns a completion strobe with read data to the granted requester. It sits between the core's memory interface (fetch and load/store, both selected by IorD upstream) and the memory macro.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width
- LATENCY, 1, memory cycles from accepted m_en to valid m_rdata; legal range 1..15
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- c_req  in  1  core request; held until c_gnt
- c_we  in  1  core write (1) / read (0)
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_be  in  DW/8  core byte enables
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core transaction complete; read data valid
- c_rdata  out  DW  core read data
- l_req, l_we, l_addr, l_wdata, l_be, l_gnt, l_rvalid, l_rdata: loader port, same widths and meaning as c_*
- l_lock  in  1  while high, core requests are never granted
- m_en  out  1  memory access strobe, one cycle per transaction
- m_we  out  1  memory write
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_be  out  DW/8  memory byte enables
- m_rdata  in  DW  memory read data, valid LATENCY cycles after m_en

## Operation
- States: IDLE, WAIT, RESP. There is one outstanding transaction at most.
- IDLE: evaluate eligible requests. Core is eligible when c_req=1 and l_lock=0; loader is eligible when l_req=1.
  - One eligible requester: grant it.
  - Both eligible: grant the one not recorded in last_owner.
  - last_owner resets to LOADER, so the core wins the first tie.
- Grant cycle (Mealy, still IDLE):
  - owner's gnt=1; m_en=1.
  - m_we/m_addr/m_wdata/m_be are taken from the owner's inputs.
  - owner and last_owner are latched.
  - Next state is RESP if LATENCY=1, else WAIT with cnt=LATENCY-2.
- WAIT: decrement cnt; at cnt=0 go to RESP. m_en=0.
- RESP:
  - owner's rvalid=1.
  - owner's rdata=m_rdata for reads; for writes rdata=0 and rvalid acts as the write ack.
  - The other port's rvalid=0 and rdata=0.
  - Next state is IDLE.
- m_* outputs are 0 when m_en=0. x_rdata is 0 whenever x_rvalid=0.
- Requester rule: drop or replace req in the cycle after gnt. A req still high in IDLE is treated as a new request.
- Requests arriving in WAIT/RESP are ignored, not queued, and are evaluated when the arbiter returns to IDLE.
- l_lock asserted while a core transaction is in flight does not abort it; lock only gates new core grants.
- cnt is 4 bits; LATENCY outside 1..15 is illegal, and RTL must carry a compile-time assertion.

## Timing
- Reset value of every output is 0. State resets to IDLE, cnt to 0, last_owner to LOADER.
- Grant at cycle t (request present with arbiter in IDLE) → rvalid at t+LATENCY → IDLE at t+LATENCY+1.
- Back-to-back throughput: one transaction per LATENCY+1 cycles. With LATENCY=1: gnt at t, rvalid at t+1, next gnt at t+2.
- Zero-cycle request-to-grant latency when the arbiter is IDLE.
- Reset asserted mid-transaction:
  - all outputs go to 0 immediately (asynchronous);
  - the pending response is discarded and never delivered;
  - the requester reissues after reset.
- A write has completed in memory on the m_en cycle; rvalid only signals completion.

## Test plan
- Core read, LATENCY=1, addr 0x0000_0010, memory returns 0xDEAD_BEEF → c_gnt at t, c_rvalid=1 with c_rdata=0xDEAD_BEEF at t+1; l_* outputs stay 0; next grant no earlier than t+2.
- Both request in the same cycle from reset, held → grant order core, loader, core, loader; each c_gnt/l_gnt separated by LATENCY+1 cycles (LATENCY=3: grants at t, t+4, t+8, t+12).
- Loader write with l_lock=1, l_addr=0x100, l_wdata=0x1234_5678, l_be=4'b0011, and c_req=1 → m_en/m_we/m_be=0011 at t, l_rvalid at t+LATENCY with l_rdata=0; c_gnt stays 0 until l_lock deasserts.
- l_lock rises one cycle after a core grant, LATENCY=4 → core read still completes with c_rvalid at t+4; no further c_gnt while locked.
- reset_n pulled low in WAIT (LATENCY=5, two cycles after grant) → all outputs 0 at once; no rvalid after release; the first tie after release goes to the core.
- Core requests during RESP and deasserts the next cycle → no grant issued; m_en never pulses for it.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core port, loader port and memory-macro side of the
// shared instruction/data memory arbiter.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW/8-1:0] c_be;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DW/8-1:0] l_be;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  logic          l_lock;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_be;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_be,
    output c_gnt, c_rvalid, c_rdata,
    input  l_req, l_we, l_addr, l_wdata, l_be, l_lock,
    output l_gnt, l_rvalid, l_rdata,
    output m_en, m_we, m_addr, m_wdata, m_be,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_be,
    input  c_gnt, c_rvalid, c_rdata,
    output l_req, l_we, l_addr, l_wdata, l_be, l_lock,
    input  l_gnt, l_rvalid, l_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_be,
    output m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin core/loader arbiter for the single-port memory,
// one transaction in flight, fixed read latency, loader lock.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {CORE, LOADER} own_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_arbiter: LATENCY must be within 1..15");
    end
  endgenerate

  state_t state, state_n;
  own_t   owner, owner_n;
  own_t   last, last_n;
  logic [3:0] cnt, cnt_n;
  logic   we_q, we_n;
  logic   c_ok, l_ok, pick_l, grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= CORE;
      last  <= LOADER;
      cnt   <= 4'd0;
      we_q  <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
      we_q  <= we_n;
    end
  end

  // Grant is gated by reset_n so held requests cannot leak out during reset.
  always_comb begin
    c_ok   = bus.c_req & ~bus.l_lock;
    l_ok   = bus.l_req;
    pick_l = l_ok & (~c_ok | (last == CORE));
    grant  = reset_n & (state == IDLE) & (c_ok | l_ok);

    state_n = state;
    owner_n = owner;
    last_n  = last;
    cnt_n   = cnt;
    we_n    = we_q;

    bus.c_gnt    = 1'b0;
    bus.c_rvalid = 1'b0;
    bus.c_rdata  = '0;
    bus.l_gnt    = 1'b0;
    bus.l_rvalid = 1'b0;
    bus.l_rdata  = '0;
    bus.m_en     = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.m_be     = '0;

    unique case (state)
      IDLE: begin
        if (grant) begin
          owner_n   = pick_l ? LOADER : CORE;
          last_n    = owner_n;
          we_n      = pick_l ? bus.l_we : bus.c_we;
          bus.c_gnt = ~pick_l;
          bus.l_gnt = pick_l;
          bus.m_en  = 1'b1;
          bus.m_we  = we_n;
          bus.m_addr  = pick_l ? bus.l_addr : bus.c_addr;
          bus.m_wdata = pick_l ? bus.l_wdata : bus.c_wdata;
          bus.m_be    = pick_l ? bus.l_be : bus.c_be;
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = RESP;
        else cnt_n = cnt - 4'd1;
      end
      RESP: begin
        state_n = IDLE;
        if (owner == LOADER) begin
          bus.l_rvalid = 1'b1;
          bus.l_rdata  = we_q ? '0 : bus.m_rdata;
        end else begin
          bus.c_rvalid = 1'b1;
          bus.c_rdata  = we_q ? '0 : bus.m_rdata;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, timing and memory contents.
module tb_mem_arbiter;
  localparam int L = 3;
  localparam int P = L + 1;

  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [16];
  logic [31:0] sh   [16];
  logic [31:0] pipe [L];

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .LATENCY(L)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // memory macro: byte-enabled writes, reads delayed by L cycles
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= 32'hA5A5_A5A5 + 32'h0101_0101 * 32'(i);
    end else if (bus.m_en && bus.m_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.m_be[b])
          mem[bus.m_addr[5:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
    end
    pipe[0] <= (bus.m_en && !bus.m_we) ? mem[bus.m_addr[5:2]] : $urandom;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.m_rdata = pipe[L-1];

  task automatic clear_inputs();
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_be = 0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0; bus.l_be = 0;
    bus.l_lock = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 16; i++)
      sh[i] = 32'hA5A5_A5A5 + 32'h0101_0101 * 32'(i);
  endtask

  task automatic test_reset();
    reset_n = 0;
    bus.c_req = 1; bus.c_we = 1; bus.c_addr = '1; bus.c_wdata = '1; bus.c_be = '1;
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = '1; bus.l_wdata = '1; bus.l_be = '1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if ({bus.c_gnt, bus.l_gnt, bus.c_rvalid, bus.l_rvalid, bus.m_en, bus.m_we}
          !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctl got %b exp 000000", {bus.c_gnt, bus.l_gnt,
                 bus.c_rvalid, bus.l_rvalid, bus.m_en, bus.m_we});
      end
      checks++;
      if ({bus.m_addr, bus.m_wdata, bus.m_be, bus.c_rdata, bus.l_rdata} !== '0) begin
        errors++;
        $display("FAIL reset_data got %h exp 0", {bus.m_addr, bus.m_wdata,
                 bus.m_be, bus.c_rdata, bus.l_rdata});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_core_read();
    logic [31:0] exp_d;
    do_reset();
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h10;
    bus.l_wdata = 32'hDEAD_BEEF; bus.l_be = 4'hF;
    #1;
    checks++;
    if (bus.l_gnt !== 1'b1) begin
      errors++; $display("FAIL preload_gnt got %b exp 1", bus.l_gnt);
    end
    @(negedge clk);
    bus.l_req = 0;
    repeat (L) @(negedge clk);
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h10; bus.c_be = 4'hF;
    #1;
    checks++;
    if ({bus.c_gnt, bus.l_gnt, bus.m_en, bus.m_we, bus.m_addr}
        !== {4'b1010, 32'h10}) begin
      errors++;
      $display("FAIL cread_gnt got %b %b %b %b %h", bus.c_gnt, bus.l_gnt,
               bus.m_en, bus.m_we, bus.m_addr);
    end
    for (int k = 1; k <= P; k++) begin
      @(negedge clk);
      if (k == 1) bus.c_addr = 32'h14;
      #1;
      exp_d = (k == L) ? 32'hDEAD_BEEF : 32'h0;
      checks++;
      if ({bus.c_gnt, bus.c_rvalid} !== {k == P, k == L}) begin
        errors++;
        $display("FAIL cread_ctl k=%0d got %b%b exp %b%b", k, bus.c_gnt,
                 bus.c_rvalid, k == P, k == L);
      end
      checks++;
      if (bus.c_rdata !== exp_d) begin
        errors++;
        $display("FAIL cread_data k=%0d got %h exp %h", k, bus.c_rdata, exp_d);
      end
      checks++;
      if ({bus.l_gnt, bus.l_rvalid, bus.l_rdata} !== 34'h0) begin
        errors++;
        $display("FAIL cread_lport k=%0d got %b %b %h", k, bus.l_gnt,
                 bus.l_rvalid, bus.l_rdata);
      end
    end
    @(negedge clk);
    bus.c_req = 0;
    repeat (L) @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit ec, el, r;
    logic [31:0] ecd, eld;
    do_reset();
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h4; bus.c_be = 4'hF;
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h8; bus.l_be = 4'hF;
    for (int k = 0; k < 4 * P; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      ec = (k % P == 0) && ((k / P) % 2 == 0);
      el = (k % P == 0) && ((k / P) % 2 == 1);
      r  = (k % P == L);
      ecd = (r && (k / P) % 2 == 0) ? sh[1] : 32'h0;
      eld = (r && (k / P) % 2 == 1) ? sh[2] : 32'h0;
      checks++;
      if ({bus.c_gnt, bus.l_gnt} !== {ec, el}) begin
        errors++;
        $display("FAIL rr_gnt k=%0d got %b%b exp %b%b", k, bus.c_gnt,
                 bus.l_gnt, ec, el);
      end
      checks++;
      if ({bus.c_rvalid, bus.l_rvalid, bus.c_rdata, bus.l_rdata}
          !== {r && (k / P) % 2 == 0, r && (k / P) % 2 == 1, ecd, eld}) begin
        errors++;
        $display("FAIL rr_resp k=%0d got %b%b %h %h exp %h %h", k,
                 bus.c_rvalid, bus.l_rvalid, bus.c_rdata, bus.l_rdata, ecd, eld);
      end
    end
    @(negedge clk);
    clear_inputs();
    repeat (P) @(negedge clk);
  endtask

  task automatic test_lock_write();
    do_reset();
    bus.l_lock = 1;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h100; bus.c_be = 4'hF;
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h100;
    bus.l_wdata = 32'h1234_5678; bus.l_be = 4'b0011;
    #1;
    checks++;
    if ({bus.l_gnt, bus.c_gnt, bus.m_en, bus.m_we, bus.m_be} !== 8'b1011_0011) begin
      errors++;
      $display("FAIL lockw_ctl got %b exp 10110011", {bus.l_gnt, bus.c_gnt,
               bus.m_en, bus.m_we, bus.m_be});
    end
    checks++;
    if ({bus.m_addr, bus.m_wdata} !== {32'h100, 32'h1234_5678}) begin
      errors++;
      $display("FAIL lockw_bus got %h %h", bus.m_addr, bus.m_wdata);
    end
    for (int k = 1; k <= L + 3; k++) begin
      @(negedge clk);
      if (k == 1) bus.l_req = 0;
      #1;
      checks++;
      if (bus.c_gnt !== 1'b0) begin
        errors++; $display("FAIL lockw_cgnt k=%0d got %b exp 0", k, bus.c_gnt);
      end
      checks++;
      if ({bus.l_rvalid, bus.l_rdata} !== {k == L, 32'h0}) begin
        errors++;
        $display("FAIL lockw_ack k=%0d got %b %h exp %b 0", k, bus.l_rvalid,
                 bus.l_rdata, k == L);
      end
    end
    @(negedge clk);
    bus.l_lock = 0;
    #1;
    checks++;
    if (bus.c_gnt !== 1'b1) begin
      errors++; $display("FAIL unlock_gnt got %b exp 1", bus.c_gnt);
    end
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (k == 1) bus.c_req = 0;
      #1;
      checks++;
      if ({bus.c_rvalid, bus.c_rdata} !==
          ((k == L) ? {1'b1, 32'hA5A5_5678} : 33'h0)) begin
        errors++;
        $display("FAIL readback k=%0d got %b %h exp a5a55678", k,
                 bus.c_rvalid, bus.c_rdata);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_lock_inflight();
    do_reset();
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h24; bus.c_be = 4'hF;
    #1;
    checks++;
    if (bus.c_gnt !== 1'b1) begin
      errors++; $display("FAIL infl_gnt got %b exp 1", bus.c_gnt);
    end
    for (int k = 1; k <= L + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.l_lock = 1;
        bus.c_addr = 32'h28;
      end
      #1;
      checks++;
      if (bus.c_gnt !== 1'b0) begin
        errors++; $display("FAIL infl_cgnt k=%0d got %b exp 0", k, bus.c_gnt);
      end
      checks++;
      if ({bus.c_rvalid, bus.c_rdata} !== ((k == L) ? {1'b1, sh[9]} : 33'h0)) begin
        errors++;
        $display("FAIL infl_resp k=%0d got %b %h exp %h", k, bus.c_rvalid,
                 bus.c_rdata, sh[9]);
      end
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    do_reset();
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h2C; bus.c_be = 4'hF;
    #1;
    checks++;
    if (bus.c_gnt !== 1'b1) begin
      errors++; $display("FAIL rstw_gnt got %b exp 1", bus.c_gnt);
    end
    @(negedge clk);
    bus.c_req = 0;
    @(negedge clk);
    bus.c_req = 1; bus.l_req = 1;
    bus.l_we = 0; bus.l_addr = 32'h30; bus.l_be = 4'hF;
    #2;
    reset_n = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if ({bus.c_gnt, bus.l_gnt, bus.c_rvalid, bus.l_rvalid, bus.m_en,
           bus.m_addr, bus.c_rdata, bus.l_rdata} !== '0) begin
        errors++;
        $display("FAIL rstw_out k=%0d got %b%b%b%b%b", k, bus.c_gnt,
                 bus.l_gnt, bus.c_rvalid, bus.l_rvalid, bus.m_en);
      end
    end
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 16; i++)
      sh[i] = 32'hA5A5_A5A5 + 32'h0101_0101 * 32'(i);
    #1;
    checks++;
    if ({bus.c_gnt, bus.l_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL rstw_tie got %b%b exp 10", bus.c_gnt, bus.l_gnt);
    end
    for (int k = 1; k <= P; k++) begin
      @(negedge clk);
      if (k == 1) bus.c_req = 0;
      #1;
      checks++;
      if ({bus.c_rvalid, bus.l_rvalid, bus.l_gnt} !== {k == L, 1'b0, k == P}) begin
        errors++;
        $display("FAIL rstw_after k=%0d got %b%b%b", k, bus.c_rvalid,
                 bus.l_rvalid, bus.l_gnt);
      end
    end
    @(negedge clk);
    clear_inputs();
    repeat (L) @(negedge clk);
  endtask

  task automatic test_resp_ignore();
    do_reset();
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h30; bus.c_be = 4'hF;
    #1;
    checks++;
    if (bus.c_gnt !== 1'b1) begin
      errors++; $display("FAIL ign_gnt got %b exp 1", bus.c_gnt);
    end
    for (int k = 1; k <= L + 4; k++) begin
      @(negedge clk);
      bus.c_req = (k == L);
      #1;
      checks++;
      if ({bus.c_gnt, bus.l_gnt, bus.m_en} !== 3'b000) begin
        errors++;
        $display("FAIL ign_men k=%0d got %b%b%b exp 000", k, bus.c_gnt,
                 bus.l_gnt, bus.m_en);
      end
      checks++;
      if (bus.c_rvalid !== (k == L)) begin
        errors++;
        $display("FAIL ign_rv k=%0d got %b exp %b", k, bus.c_rvalid, k == L);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    int idle_at, resp_at;
    bit lo, rl, rwe, cg, lg, ce, le, idle, eg_c, eg_l, rv;
    logic [31:0] rd, a, wd;
    logic [3:0] be;
    logic [69:0] mexp;
    logic [31:0] ecd, eld;
    do_reset();
    idle_at = 0; resp_at = -1;
    lo = 1; rl = 0; rwe = 0; cg = 0; lg = 0; rd = 0;
    for (int t = 0; t < n; t++) begin
      if (t > 0) @(negedge clk);
      if (!bus.c_req || cg) begin
        bus.c_req = 1'($urandom_range(0, 1));
        bus.c_we = 1'($urandom_range(0, 1));
        bus.c_addr = $urandom; bus.c_wdata = $urandom; bus.c_be = 4'($urandom);
      end
      if (!bus.l_req || lg) begin
        bus.l_req = 1'($urandom_range(0, 1));
        bus.l_we = 1'($urandom_range(0, 1));
        bus.l_addr = $urandom; bus.l_wdata = $urandom; bus.l_be = 4'($urandom);
      end
      if ($urandom_range(0, 7) == 0) bus.l_lock = ~bus.l_lock;
      #1;
      ce = bus.c_req && !bus.l_lock;
      le = bus.l_req;
      idle = (t >= idle_at);
      eg_l = idle && le && (!ce || !lo);
      eg_c = idle && ce && !eg_l;
      mexp = eg_c ? {2'b1, bus.c_we, bus.c_addr, bus.c_wdata, bus.c_be} :
             eg_l ? {2'b1, bus.l_we, bus.l_addr, bus.l_wdata, bus.l_be} : 70'h0;
      mexp[69] = eg_c || eg_l;
      rv = (t == resp_at);
      ecd = (rv && !rl && !rwe) ? rd : 32'h0;
      eld = (rv && rl && !rwe) ? rd : 32'h0;
      checks++;
      if ({bus.c_gnt, bus.l_gnt} !== {eg_c, eg_l}) begin
        errors++;
        $display("FAIL rnd_gnt t=%0d got %b%b exp %b%b", t, bus.c_gnt,
                 bus.l_gnt, eg_c, eg_l);
      end
      checks++;
      if ({bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be} !== mexp) begin
        errors++;
        $display("FAIL rnd_mbus t=%0d got %h exp %h", t, {bus.m_en, bus.m_we,
                 bus.m_addr, bus.m_wdata, bus.m_be}, mexp);
      end
      checks++;
      if ({bus.c_rvalid, bus.l_rvalid} !== {rv && !rl, rv && rl}) begin
        errors++;
        $display("FAIL rnd_rv t=%0d got %b%b exp %b%b", t, bus.c_rvalid,
                 bus.l_rvalid, rv && !rl, rv && rl);
      end
      checks++;
      if ({bus.c_rdata, bus.l_rdata} !== {ecd, eld}) begin
        errors++;
        $display("FAIL rnd_rdata t=%0d got %h %h exp %h %h", t, bus.c_rdata,
                 bus.l_rdata, ecd, eld);
      end
      if (eg_c || eg_l) begin
        lo = eg_l;
        rl = eg_l;
        idle_at = t + P;
        resp_at = t + L;
        rwe = eg_l ? bus.l_we : bus.c_we;
        a   = eg_l ? bus.l_addr : bus.c_addr;
        wd  = eg_l ? bus.l_wdata : bus.c_wdata;
        be  = eg_l ? bus.l_be : bus.c_be;
        rd  = sh[a[5:2]];
        if (rwe)
          for (int b = 0; b < 4; b++)
            if (be[b]) sh[a[5:2]][8*b +: 8] = wd[8*b +: 8];
      end
      cg = eg_c;
      lg = eg_l;
    end
    @(negedge clk);
    clear_inputs();
    repeat (P) @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    do_reset();
    test_reset();
    test_core_read();
    test_round_robin();
    test_lock_write();
    test_lock_inflight();
    test_reset_wait();
    test_resp_ignore();
    test_random(600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
